// File: rtl/nmea_sentence_ctrl_if.sv
// Bundles the sentence-controller signals between the receiver/host side and the controller.
// master drives the receiver fields and the downstream ready; slave is the controller itself.
interface nmea_sentence_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic             i_enable;
  logic             i_char_valid;
  logic             i_end;
  logic             i_check;
  logic [15:0]      i_ti;
  logic [23:0]      i_si;
  logic [7:0]       i_fieldcnt;
  logic             i_filter_en;
  logic [23:0]      i_filter_si;
  logic             i_clr_stats;
  logic             i_ready;
  logic             o_valid;
  logic [15:0]      o_ti;
  logic [23:0]      o_si;
  logic [7:0]       o_fieldcnt;
  logic [CNT_W-1:0] o_good_cnt;
  logic [CNT_W-1:0] o_bad_cnt;
  logic [CNT_W-1:0] o_filt_cnt;
  logic [CNT_W-1:0] o_drop_cnt;
  logic             o_timeout;
  logic             o_busy;

  modport master (
    output i_enable, i_char_valid, i_end, i_check, i_ti, i_si, i_fieldcnt,
           i_filter_en, i_filter_si, i_clr_stats, i_ready,
    input  o_valid, o_ti, o_si, o_fieldcnt, o_good_cnt, o_bad_cnt, o_filt_cnt,
           o_drop_cnt, o_timeout, o_busy
  );

  modport slave (
    input  i_enable, i_char_valid, i_end, i_check, i_ti, i_si, i_fieldcnt,
           i_filter_en, i_filter_si, i_clr_stats, i_ready,
    output o_valid, o_ti, o_si, o_fieldcnt, o_good_cnt, o_bad_cnt, o_filt_cnt,
           o_drop_cnt, o_timeout, o_busy
  );
endinterface

// File: rtl/nmea_sentence_ctrl.sv
// NMEA sentence controller: captures a decoded sentence on the receiver's end edge,
// screens it (checksum, sentence filter), holds it for a ready handshake and keeps statistics.
module nmea_sentence_ctrl #(
  parameter logic [15:0] TIMEOUT_CYC = 16'd50000,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  nmea_sentence_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, WAIT, EVAL, HOLD} state_e;

  state_e           state_q, state_d;
  logic             end_q, end_edge;
  logic             chk_q, chk_d;
  logic [15:0]      cap_ti_q, cap_ti_d;
  logic [23:0]      cap_si_q, cap_si_d;
  logic [7:0]       cap_fc_q, cap_fc_d;
  logic             valid_q, valid_d;
  logic [15:0]      ti_q, ti_d;
  logic [23:0]      si_q, si_d;
  logic [7:0]       fc_q, fc_d;
  logic             inc_good, inc_bad, inc_filt, inc_drop;
  logic [CNT_W-1:0] good_q, bad_q, filt_q, drop_q;
  logic [15:0]      idle_q;

  // Clear beats a same-cycle increment; increments stop at all-ones.
  function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] cnt,
                                            input logic inc, input logic clr);
    if (clr) return '0;
    if (inc && (cnt != {CNT_W{1'b1}})) return cnt + CNT_W'(1);
    return cnt;
  endfunction

  assign end_edge = bus.i_end & ~end_q;

  always_comb begin
    state_d  = state_q;
    chk_d    = chk_q;
    cap_ti_d = cap_ti_q;
    cap_si_d = cap_si_q;
    cap_fc_d = cap_fc_q;
    valid_d  = valid_q;
    ti_d     = ti_q;
    si_d     = si_q;
    fc_d     = fc_q;
    inc_good = 1'b0;
    inc_bad  = 1'b0;
    inc_filt = 1'b0;
    inc_drop = 1'b0;
    if (!bus.i_enable) begin
      state_d = IDLE;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: state_d = WAIT;
        WAIT: if (end_edge) begin
          chk_d    = bus.i_check;
          cap_ti_d = bus.i_ti;
          cap_si_d = bus.i_si;
          cap_fc_d = bus.i_fieldcnt;
          state_d  = EVAL;
        end
        EVAL: begin
          inc_drop = end_edge;
          if (!chk_q) begin
            inc_bad = 1'b1;
            state_d = WAIT;
          end else if (bus.i_filter_en && (cap_si_q != bus.i_filter_si)) begin
            inc_filt = 1'b1;
            state_d  = WAIT;
          end else begin
            ti_d    = cap_ti_q;
            si_d    = cap_si_q;
            fc_d    = cap_fc_q;
            valid_d = 1'b1;
            state_d = HOLD;
          end
        end
        HOLD: begin
          inc_drop = end_edge;
          if (bus.i_ready) begin
            inc_good = 1'b1;
            valid_d  = 1'b0;
            state_d  = WAIT;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q  <= IDLE;
      end_q    <= 1'b0;
      chk_q    <= 1'b0;
      cap_ti_q <= '0;
      cap_si_q <= '0;
      cap_fc_q <= '0;
      valid_q  <= 1'b0;
      ti_q     <= '0;
      si_q     <= '0;
      fc_q     <= '0;
      good_q   <= '0;
      bad_q    <= '0;
      filt_q   <= '0;
      drop_q   <= '0;
      idle_q   <= '0;
    end else begin
      state_q  <= state_d;
      end_q    <= bus.i_end;
      chk_q    <= chk_d;
      cap_ti_q <= cap_ti_d;
      cap_si_q <= cap_si_d;
      cap_fc_q <= cap_fc_d;
      valid_q  <= valid_d;
      ti_q     <= ti_d;
      si_q     <= si_d;
      fc_q     <= fc_d;
      good_q   <= bump(good_q, inc_good, bus.i_clr_stats);
      bad_q    <= bump(bad_q,  inc_bad,  bus.i_clr_stats);
      filt_q   <= bump(filt_q, inc_filt, bus.i_clr_stats);
      drop_q   <= bump(drop_q, inc_drop, bus.i_clr_stats);
      if (bus.i_char_valid)          idle_q <= '0;
      else if (idle_q < TIMEOUT_CYC) idle_q <= idle_q + 16'd1;
    end
  end

  assign bus.o_valid    = valid_q;
  assign bus.o_ti       = ti_q;
  assign bus.o_si       = si_q;
  assign bus.o_fieldcnt = fc_q;
  assign bus.o_good_cnt = good_q;
  assign bus.o_bad_cnt  = bad_q;
  assign bus.o_filt_cnt = filt_q;
  assign bus.o_drop_cnt = drop_q;
  // The idle counter keeps running in IDLE; only the flag is masked there.
  assign bus.o_timeout  = (state_q != IDLE) && (idle_q == TIMEOUT_CYC);
  assign bus.o_busy     = (state_q == EVAL) || (state_q == HOLD);

endmodule

// File: tb/tb_nmea_sentence_ctrl.sv
// Directed bench for nmea_sentence_ctrl, built with TIMEOUT_CYC=8 and CNT_W=4.
module tb_nmea_sentence_ctrl;
  localparam logic [23:0] SI_GGA = 24'h474741;
  localparam logic [23:0] SI_RMC = 24'h524D43;
  localparam logic [15:0] TI_GP  = 16'h4750;
  localparam logic [15:0] TI_GN  = 16'h474E;

  logic clk, rst;
  int   errs, checks;

  nmea_sentence_ctrl_if #(.CNT_W(4)) bus ();
  nmea_sentence_ctrl #(.TIMEOUT_CYC(16'd8), .CNT_W(4)) dut (
    .i_clk(clk), .i_rst(rst), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Raises i_end for one cycle; returns #1 after the edge that samples it.
  task automatic send_edge(input logic chk, input logic [15:0] ti,
                           input logic [23:0] si, input logic [7:0] fc);
    bus.i_check = chk; bus.i_ti = ti; bus.i_si = si; bus.i_fieldcnt = fc;
    bus.i_end = 1'b1;
    tick();
    bus.i_end = 1'b0;
  endtask

  task automatic clr_stats();
    bus.i_clr_stats = 1'b1;
    tick();
    bus.i_clr_stats = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.i_enable = 1'b0; bus.i_char_valid = 1'b0; bus.i_end = 1'b0; bus.i_check = 1'b0;
    bus.i_ti = '0; bus.i_si = '0; bus.i_fieldcnt = '0; bus.i_filter_en = 1'b0;
    bus.i_filter_si = '0; bus.i_clr_stats = 1'b0; bus.i_ready = 1'b1;
    tick(); tick();
    checks++;
    if ({bus.o_valid, bus.o_ti, bus.o_si, bus.o_fieldcnt, bus.o_good_cnt, bus.o_bad_cnt,
         bus.o_filt_cnt, bus.o_drop_cnt, bus.o_timeout, bus.o_busy} !== '0) begin
      errs++; $display("FAIL reset_outputs: valid=%0b si=%h good=%0d bad=%0d timeout=%0b busy=%0b, want all 0",
                       bus.o_valid, bus.o_si, bus.o_good_cnt, bus.o_bad_cnt, bus.o_timeout, bus.o_busy);
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_good();
    bus.i_enable = 1'b1;
    tick();
    send_edge(1'b1, TI_GP, SI_GGA, 8'd14);
    checks++;
    if (bus.o_valid !== 1'b0 || bus.o_busy !== 1'b1) begin
      errs++; $display("FAIL good_n1: valid=%0b busy=%0b, want valid=0 busy=1", bus.o_valid, bus.o_busy);
    end
    tick();
    checks++;
    if (bus.o_valid !== 1'b1) begin
      errs++; $display("FAIL good_n2_valid: got %0b want 1", bus.o_valid);
    end
    checks++;
    if (bus.o_si !== SI_GGA || bus.o_ti !== TI_GP || bus.o_fieldcnt !== 8'd14) begin
      errs++; $display("FAIL good_record: si=%h ti=%h fc=%0d want si=474741 ti=4750 fc=14",
                       bus.o_si, bus.o_ti, bus.o_fieldcnt);
    end
    tick();
    checks++;
    if (bus.o_valid !== 1'b0 || bus.o_good_cnt !== 4'd1 || bus.o_busy !== 1'b0) begin
      errs++; $display("FAIL good_handshake: valid=%0b good=%0d busy=%0b want 0/1/0",
                       bus.o_valid, bus.o_good_cnt, bus.o_busy);
    end
  endtask

  task automatic test_bad();
    clr_stats();
    send_edge(1'b0, TI_GP, SI_RMC, 8'd12);
    tick();
    checks++;
    if (bus.o_valid !== 1'b0 || bus.o_bad_cnt !== 4'd1 || bus.o_good_cnt !== 4'd0) begin
      errs++; $display("FAIL bad_checksum: valid=%0b bad=%0d good=%0d want 0/1/0",
                       bus.o_valid, bus.o_bad_cnt, bus.o_good_cnt);
    end
  endtask

  task automatic test_filter();
    clr_stats();
    bus.i_filter_en = 1'b1; bus.i_filter_si = SI_RMC;
    send_edge(1'b1, TI_GP, SI_GGA, 8'd14);
    tick();
    checks++;
    if (bus.o_valid !== 1'b0 || bus.o_filt_cnt !== 4'd1 || bus.o_bad_cnt !== 4'd0) begin
      errs++; $display("FAIL filter_reject: valid=%0b filt=%0d bad=%0d want 0/1/0",
                       bus.o_valid, bus.o_filt_cnt, bus.o_bad_cnt);
    end
    // Matching sentence passes the filter.
    send_edge(1'b1, TI_GN, SI_RMC, 8'd12);
    tick();
    checks++;
    if (bus.o_valid !== 1'b1 || bus.o_si !== SI_RMC || bus.o_filt_cnt !== 4'd1) begin
      errs++; $display("FAIL filter_accept: valid=%0b si=%h filt=%0d want 1/524d43/1",
                       bus.o_valid, bus.o_si, bus.o_filt_cnt);
    end
    tick();
    bus.i_filter_en = 1'b0;
  endtask

  task automatic test_hold_drop();
    clr_stats();
    bus.i_ready = 1'b0;
    send_edge(1'b1, TI_GP, SI_GGA, 8'd14);
    tick();
    repeat (5) tick();
    send_edge(1'b1, TI_GN, SI_RMC, 8'd12);
    checks++;
    if (bus.o_drop_cnt !== 4'd1) begin
      errs++; $display("FAIL hold_drop_cnt: got %0d want 1", bus.o_drop_cnt);
    end
    repeat (13) tick();
    checks++;
    if (bus.o_valid !== 1'b1 || bus.o_busy !== 1'b1) begin
      errs++; $display("FAIL hold_valid: valid=%0b busy=%0b want 1/1", bus.o_valid, bus.o_busy);
    end
    checks++;
    if (bus.o_si !== SI_GGA || bus.o_ti !== TI_GP || bus.o_fieldcnt !== 8'd14) begin
      errs++; $display("FAIL hold_record: si=%h ti=%h fc=%0d want 474741/4750/14",
                       bus.o_si, bus.o_ti, bus.o_fieldcnt);
    end
    checks++;
    if (bus.o_good_cnt !== 4'd0) begin
      errs++; $display("FAIL hold_no_good: got %0d want 0", bus.o_good_cnt);
    end
    bus.i_ready = 1'b1;
    tick();
    checks++;
    if (bus.o_valid !== 1'b0 || bus.o_good_cnt !== 4'd1 || bus.o_drop_cnt !== 4'd1) begin
      errs++; $display("FAIL hold_release: valid=%0b good=%0d drop=%0d want 0/1/1",
                       bus.o_valid, bus.o_good_cnt, bus.o_drop_cnt);
    end
  endtask

  task automatic test_back_to_back();
    clr_stats();
    send_edge(1'b1, TI_GP, SI_GGA, 8'd14);
    tick(); tick();
    send_edge(1'b1, TI_GN, SI_RMC, 8'd12);
    tick();
    checks++;
    if (bus.o_valid !== 1'b1 || bus.o_si !== SI_RMC || bus.o_ti !== TI_GN) begin
      errs++; $display("FAIL b2b_second: valid=%0b si=%h ti=%h want 1/524d43/474e",
                       bus.o_valid, bus.o_si, bus.o_ti);
    end
    tick();
    checks++;
    if (bus.o_good_cnt !== 4'd2 || bus.o_drop_cnt !== 4'd0) begin
      errs++; $display("FAIL b2b_counts: good=%0d drop=%0d want 2/0", bus.o_good_cnt, bus.o_drop_cnt);
    end
  endtask

  task automatic test_timeout();
    bus.i_char_valid = 1'b1;
    tick();
    bus.i_char_valid = 1'b0;
    checks++;
    if (bus.o_timeout !== 1'b0) begin
      errs++; $display("FAIL timeout_after_char: got %0b want 0", bus.o_timeout);
    end
    repeat (7) tick();
    checks++;
    if (bus.o_timeout !== 1'b0) begin
      errs++; $display("FAIL timeout_7: got %0b want 0", bus.o_timeout);
    end
    tick();
    checks++;
    if (bus.o_timeout !== 1'b1) begin
      errs++; $display("FAIL timeout_8: got %0b want 1", bus.o_timeout);
    end
    repeat (3) tick();
    checks++;
    if (bus.o_timeout !== 1'b1) begin
      errs++; $display("FAIL timeout_sat: got %0b want 1", bus.o_timeout);
    end
    bus.i_char_valid = 1'b1;
    tick();
    bus.i_char_valid = 1'b0;
    checks++;
    if (bus.o_timeout !== 1'b0) begin
      errs++; $display("FAIL timeout_clear: got %0b want 0", bus.o_timeout);
    end
  endtask

  task automatic test_saturate();
    clr_stats();
    for (int i = 0; i < 15; i++) begin
      send_edge(1'b0, TI_GP, SI_GGA, 8'd1);
      tick();
    end
    checks++;
    if (bus.o_bad_cnt !== 4'hF) begin
      errs++; $display("FAIL sat_15: got %h want f", bus.o_bad_cnt);
    end
    send_edge(1'b0, TI_GP, SI_GGA, 8'd1);
    tick();
    checks++;
    if (bus.o_bad_cnt !== 4'hF) begin
      errs++; $display("FAIL sat_16: got %h want f", bus.o_bad_cnt);
    end
    send_edge(1'b0, TI_GP, SI_GGA, 8'd1);
    bus.i_clr_stats = 1'b1;
    tick();
    bus.i_clr_stats = 1'b0;
    checks++;
    if (bus.o_bad_cnt !== 4'h0) begin
      errs++; $display("FAIL sat_clr_wins: got %h want 0", bus.o_bad_cnt);
    end
  endtask

  task automatic test_enable_drop();
    clr_stats();
    bus.i_ready = 1'b0;
    send_edge(1'b1, TI_GP, SI_GGA, 8'd14);
    tick(); tick();
    checks++;
    if (bus.o_valid !== 1'b1) begin
      errs++; $display("FAIL en_hold_setup: valid=%0b want 1", bus.o_valid);
    end
    bus.i_enable = 1'b0;
    bus.i_ready = 1'b1;
    tick();
    checks++;
    if (bus.o_valid !== 1'b0 || bus.o_busy !== 1'b0 || bus.o_good_cnt !== 4'd0) begin
      errs++; $display("FAIL en_drop: valid=%0b busy=%0b good=%0d want 0/0/0",
                       bus.o_valid, bus.o_busy, bus.o_good_cnt);
    end
    send_edge(1'b0, TI_GP, SI_GGA, 8'd1);
    tick(); tick();
    checks++;
    if (bus.o_bad_cnt !== 4'd0 || bus.o_drop_cnt !== 4'd0 || bus.o_busy !== 1'b0) begin
      errs++; $display("FAIL idle_edge_ignored: bad=%0d drop=%0d busy=%0b want 0/0/0",
                       bus.o_bad_cnt, bus.o_drop_cnt, bus.o_busy);
    end
    repeat (10) tick();
    checks++;
    if (bus.o_timeout !== 1'b0) begin
      errs++; $display("FAIL idle_timeout_masked: got %0b want 0", bus.o_timeout);
    end
    bus.i_enable = 1'b1;
    tick();
    checks++;
    if (bus.o_timeout !== 1'b1) begin
      errs++; $display("FAIL wait_timeout_unmasked: got %0b want 1", bus.o_timeout);
    end
  endtask

  task automatic test_reset_hold();
    bus.i_char_valid = 1'b1;
    tick();
    bus.i_char_valid = 1'b0;
    bus.i_ready = 1'b0;
    send_edge(1'b1, TI_GP, SI_GGA, 8'd14);
    tick(); tick();
    send_edge(1'b1, TI_GN, SI_RMC, 8'd12);
    checks++;
    if (bus.o_valid !== 1'b1 || bus.o_drop_cnt !== 4'd1) begin
      errs++; $display("FAIL rst_hold_setup: valid=%0b drop=%0d want 1/1", bus.o_valid, bus.o_drop_cnt);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({bus.o_valid, bus.o_ti, bus.o_si, bus.o_fieldcnt, bus.o_good_cnt, bus.o_bad_cnt,
         bus.o_filt_cnt, bus.o_drop_cnt, bus.o_timeout, bus.o_busy} !== '0) begin
      errs++; $display("FAIL rst_mid_hold: valid=%0b si=%h drop=%0d good=%0d busy=%0b want all 0",
                       bus.o_valid, bus.o_si, bus.o_drop_cnt, bus.o_good_cnt, bus.o_busy);
    end
    bus.i_ready = 1'b1;
    tick();
    rst = 1'b1;
    tick(); tick();
    checks++;
    if (bus.o_valid !== 1'b0 || bus.o_good_cnt !== 4'd0 || bus.o_busy !== 1'b0) begin
      errs++; $display("FAIL rst_no_handshake: valid=%0b good=%0d busy=%0b want 0/0/0",
                       bus.o_valid, bus.o_good_cnt, bus.o_busy);
    end
  endtask

  initial begin
    errs = 0;
    checks = 0;
    test_reset();
    test_good();
    test_bad();
    test_filter();
    test_hold_drop();
    test_back_to_back();
    test_timeout();
    test_saturate();
    test_enable_drop();
    test_reset_hold();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
